uart_alu_intf: RTL and testbench

Frame assembler/dispatcher directly downstream of the UART receiver. Consumes received bytes (data + one-cycle done strobe), assembles a 3-byte command frame (opcode, operand A, operand B), and drives the combinational ALU with the frame's operands. It then hands the ALU result to the UART transmitter with a start/done handshake. A per-byte inactivity timeout discards partial frames.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/intf_timeout_cnt.sv | 27 ++
 rtl/uart_alu_intf.sv | 81 ++++++++
 tb/tb_uart_alu_intf.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART/ALU frame interface: state encoding, opcodes, helpers.
package uart_pkg;

  localparam int NB_STATE = 6;

  localparam logic [NB_STATE-1:0] ST_WAIT_OP = 6'b000001;
  localparam logic [NB_STATE-1:0] ST_WAIT_A  = 6'b000010;
  localparam logic [NB_STATE-1:0] ST_WAIT_B  = 6'b000100;
  localparam logic [NB_STATE-1:0] ST_CALC    = 6'b001000;
  localparam logic [NB_STATE-1:0] ST_SEND    = 6'b010000;
  localparam logic [NB_STATE-1:0] ST_WAIT_TX = 6'b100000;

  typedef enum logic [NB_STATE-1:0] {
    WAIT_OP = ST_WAIT_OP,
    WAIT_A  = ST_WAIT_A,
    WAIT_B  = ST_WAIT_B,
    CALC    = ST_CALC,
    SEND    = ST_SEND,
    WAIT_TX = ST_WAIT_TX
  } state_t;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] NOR = 6'b100111;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/intf_timeout_cnt.sv
// Inter-byte inactivity counter; o_expired flags the last allowed idle cycle.
module intf_timeout_cnt
  import uart_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)      cnt <= '0;
    else if (i_clear)  cnt <= '0;
    else if (i_enable) cnt <= cnt + 1'b1;
  end

  // TIMEOUT of zero disables expiry entirely; the counter is then don't-care.
  assign o_expired = (TIMEOUT != 0) && i_enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/uart_alu_intf.sv
// Assembles opcode/A/B frames from the UART receiver, drives the ALU and hands the result to the transmitter.
module uart_alu_intf
  import uart_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int TIMEOUT = 50000
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_timeout,
  output logic               o_drop
);

  state_t state, state_nxt;
  logic   collecting, busy, tmo_clear, expired, tmo;

  assign collecting = (state == WAIT_A) || (state == WAIT_B);
  assign busy       = (state == CALC) || (state == SEND) || (state == WAIT_TX);
  assign tmo_clear  = !collecting || i_rx_done;
  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo        = expired && !i_rx_done;

  intf_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (tmo_clear),
    .i_enable  (collecting),
    .o_expired (expired)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= WAIT_OP;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_OP: if (i_rx_done) state_nxt = WAIT_A;
      WAIT_A:  if (i_rx_done) state_nxt = WAIT_B;
               else if (tmo) state_nxt = WAIT_OP;
      WAIT_B:  if (i_rx_done) state_nxt = CALC;
               else if (tmo) state_nxt = WAIT_OP;
      CALC:    state_nxt = SEND;
      SEND:    state_nxt = WAIT_TX;
      WAIT_TX: if (i_tx_done) state_nxt = WAIT_OP;
      default: state_nxt = WAIT_OP;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      o_tx_start <= (state == CALC);
      o_timeout  <= tmo;
      o_drop     <= i_rx_done && busy;
      if (i_rx_done && state == WAIT_OP) o_alu_op <= i_rx_data[NB_OP-1:0];
      if (i_rx_done && state == WAIT_A)  o_alu_a  <= i_rx_data;
      if (i_rx_done && state == WAIT_B)  o_alu_b  <= i_rx_data;
      if (state == CALC)                 o_tx_data <= i_alu_result;
    end
  end

endmodule

// File: tb/tb_uart_alu_intf.sv
// Randomized + directed bench for uart_alu_intf against a byte/frame-level reference model.
module tb_uart_alu_intf;
  import uart_pkg::*;

  localparam int TMO = 20;

  logic       clk = 1'b0, rst_n = 1'b0, rx_done = 1'b0, tx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] alu_res, alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, timeout, drop;

  int n_pass = 0, n_chk = 0;
  int cyc = 0, last_rx = 0, start_cyc = 0, n_start = 0, n_tmo = 0, n_drop = 0;

  // reference model state
  logic [5:0] m_op = '0;
  logic [7:0] m_a = '0, m_b = '0, m_txd = '0;
  logic       m_start = 0, m_to = 0, m_drop = 0, m_busy = 0;
  int         m_nb = 0, m_age = 0, m_idle = 0;

  always #5 clk = ~clk;

  uart_alu_intf #(.NB_DATA(8), .NB_OP(6), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_alu_result (alu_res),
    .i_tx_done    (tx_done),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_timeout    (timeout),
    .o_drop       (drop)
  );

  function automatic logic [7:0] alu(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      SRA:     return 8'($signed(a) >>> b);
      SRL:     return a >> b;
      NOR:     return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_res = alu(alu_op, alu_a, alu_b);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Model: counts bytes of the current frame, ages the busy window after the third byte.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_op = '0; m_a = '0; m_b = '0; m_txd = '0;
      m_start = 0; m_to = 0; m_drop = 0; m_busy = 0;
      m_nb = 0; m_age = 0; m_idle = 0;
    end else begin
      m_start = 0; m_to = 0; m_drop = 0;
      if (m_busy) begin
        m_drop = rx_done;
        if (m_age == 1) begin
          m_txd   = alu(m_op, m_a, m_b);
          m_start = 1;
        end
        if (m_age >= 3 && tx_done) m_busy = 0;
        m_age++;
      end else if (rx_done) begin
        case (m_nb)
          0:       m_op = rx_data[5:0];
          1:       m_a  = rx_data;
          default: m_b  = rx_data;
        endcase
        m_idle = 0;
        if (m_nb == 2) begin
          m_nb = 0; m_busy = 1; m_age = 1;
        end else m_nb++;
      end else if (m_nb > 0) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_nb = 0; m_idle = 0; m_to = 1;
        end
      end
    end
  end

  // Per-cycle compare and pulse bookkeeping, away from the active edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("o_alu_op",   64'(alu_op),   64'(m_op));
      chk("o_alu_a",    64'(alu_a),    64'(m_a));
      chk("o_alu_b",    64'(alu_b),    64'(m_b));
      chk("o_tx_data",  64'(tx_data),  64'(m_txd));
      chk("o_tx_start", 64'(tx_start), 64'(m_start));
      chk("o_timeout",  64'(timeout),  64'(m_to));
      chk("o_drop",     64'(drop),     64'(m_drop));
      if (tx_start) begin start_cyc = cyc; n_start++; end
      if (timeout) n_tmo++;
      if (drop) n_drop++;
    end
  end

  task automatic drive(input logic rx, input logic [7:0] d, input logic tx);
    @(posedge clk);
    #2;
    rx_done = rx; rx_data = d; tx_done = tx;
    if (rx) last_rx = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] d);
    drive(1'b1, d, 1'b0);
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int gap, input logic [7:0] exp_res, input string nm);
    int s0, t0;
    t0 = n_tmo;
    send_byte(op); idle(gap);
    send_byte(a);  idle(gap);
    send_byte(b);
    s0 = n_start;
    idle(8);
    chk({nm, "_result"}, 64'(tx_data), 64'(exp_res));
    chk({nm, "_op"}, 64'(alu_op), 64'(op[5:0]));
    chk({nm, "_start_lat"}, 64'(start_cyc - last_rx), 64'd2);
    chk({nm, "_start_cnt"}, 64'(n_start - s0), 64'd1);
    chk({nm, "_no_tmo"}, 64'(n_tmo - t0), 64'd0);
    drive(1'b0, 8'h00, 1'b1);
    idle(2);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0; rx_done = 1'b0; tx_done = 1'b0;
    #1;
    chk("rst_ops", 64'({alu_op, alu_a, alu_b}), 64'd0);
    chk("rst_tx", 64'({tx_data, tx_start, timeout, drop}), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int s0, t0, d0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("reset_ops", 64'({alu_op, alu_a, alu_b}), 64'd0);
    chk("reset_tx", 64'({tx_data, tx_start, timeout, drop}), 64'd0);
    idle(2);

    run_frame(8'h20, 8'h05, 8'h03, 2, 8'h08, "add");
    run_frame(8'h22, 8'h03, 8'h05, 1, 8'hFE, "sub");
    // byte arriving on the final allowed idle cycle is still accepted
    run_frame(8'h20, 8'h07, 8'h01, TMO - 1, 8'h08, "edge_gap");

    t0 = n_tmo; s0 = n_start;
    send_byte(8'h20); send_byte(8'h07);
    idle(TMO + 2);
    chk("timeout_pulse", 64'(n_tmo - t0), 64'd1);
    chk("timeout_no_start", 64'(n_start - s0), 64'd0);
    chk("timeout_keeps_a", 64'(alu_a), 64'h07);
    run_frame(8'h24, 8'h0F, 8'h3C, 1, 8'h0C, "and");

    send_byte(8'h26); send_byte(8'h0F); send_byte(8'hF0);
    idle(4);
    d0 = n_drop; s0 = n_start;
    send_byte(8'hAA);
    idle(1);
    drive(1'b0, 8'h00, 1'b0);
    chk("drop_pulse", 64'(n_drop - d0), 64'd1);
    chk("drop_ops", 64'({alu_op, alu_a, alu_b}), 64'({6'h26, 8'h0F, 8'hF0}));
    chk("drop_txd", 64'(tx_data), 64'hFF);
    chk("drop_no_start", 64'(n_start - s0), 64'd0);
    drive(1'b0, 8'h00, 1'b1);
    idle(2);

    run_frame(8'h25, 8'h50, 8'h0A, 0, 8'h5A, "b2b");

    send_byte(8'h20); send_byte(8'h11);
    pulse_reset();
    run_frame(8'h20, 8'h11, 8'h22, 1, 8'h33, "post_rst");

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 7))
          0: d = {2'b00, ADD}; 1: d = {2'b00, SUB}; 2: d = {2'b11, AND}; 3: d = {2'b00, OR};
          4: d = {2'b01, XOR}; 5: d = {2'b00, SRA}; 6: d = {2'b10, SRL}; default: d = {2'b00, NOR};
        endcase
      end else d = 8'($urandom);
      if ($urandom_range(0, 199) == 0) idle($urandom_range(TMO - 2, TMO + 2));
      else if ($urandom_range(0, 999) == 0) pulse_reset();
      else drive($urandom_range(0, 2) == 0, d, $urandom_range(0, 7) == 0);
    end
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
